// File: rtl/ibus_dma_channel_pkg.sv
// Shared types and helpers for the IBUS DMA channel: state, element size,
// address mode, byte-lane mask and address arithmetic.
package ibus_dma_channel_pkg;

    typedef enum logic [1:0] {IDLE, RD, WR, END} DMA_STATE_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_WORD, SZ_LONG, SZ_RSVD} DMA_SIZE_t;
    typedef enum logic [1:0] {AM_FIXED, AM_INC, AM_DEC, AM_FIXED_ALT} DMA_AMODE_t;

    // Big-endian lanes: BA[3] carries bits 31:24, i.e. the byte at A[1:0]=0.
    function automatic logic [3:0] DMA_BA(input DMA_SIZE_t size, input logic [1:0] a10);
        case (size)
            SZ_BYTE: return 4'b1000 >> a10;
            SZ_WORD: return a10[1] ? 4'b0011 : 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic dma_misaligned(input DMA_SIZE_t size, input logic [1:0] a10);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_WORD: return a10[0];
            default: return |a10;
        endcase
    endfunction

    function automatic logic [2:0] dma_unit(input DMA_SIZE_t size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_WORD: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] dma_step(input DMA_AMODE_t mode, input logic [31:0] a,
                                             input logic [2:0] unit);
        case (mode)
            AM_INC:  return a + {29'd0, unit};
            AM_DEC:  return a - {29'd0, unit};
            default: return a;
        endcase
    endfunction

endpackage

// File: rtl/ibus_dma_channel_lane_align.sv
// Combinational byte-lane steering: right-justifies read data taken from the
// addressed lanes and replicates write data across all lanes.
module ibus_lane_align
    import ibus_dma_channel_pkg::*;
(
    input  DMA_SIZE_t   size,
    input  logic [1:0]  a10,
    input  logic [31:0] rd_in,
    input  logic [31:0] wr_in,
    output logic [31:0] rd_out,
    output logic [31:0] wr_out
);

    always_comb begin
        rd_out = rd_in;
        wr_out = wr_in;
        case (size)
            SZ_BYTE: begin
                case (a10)
                    2'd0:    rd_out = {24'd0, rd_in[31:24]};
                    2'd1:    rd_out = {24'd0, rd_in[23:16]};
                    2'd2:    rd_out = {24'd0, rd_in[15:8]};
                    default: rd_out = {24'd0, rd_in[7:0]};
                endcase
                wr_out = {4{wr_in[7:0]}};
            end
            SZ_WORD: begin
                rd_out = a10[1] ? {16'd0, rd_in[15:0]} : {16'd0, rd_in[31:16]};
                wr_out = {2{wr_in[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ibus_dma_channel.sv
// Single-channel memory-to-memory DMA engine acting as an IBUS initiator:
// one read then one write per element, honouring IBUS_BUSY wait states.
module ibus_dma_channel
    import ibus_dma_channel_pkg::*;
#(
    parameter int TCR_W = 24
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE_R,
    input  logic             START,
    input  logic             ABORT,
    input  logic [31:0]      SRC,
    input  logic [31:0]      DST,
    input  logic [TCR_W-1:0] COUNT,
    input  logic [1:0]       SIZE,
    input  logic [1:0]       SM,
    input  logic [1:0]       DM,
    output logic [31:0]      IBUS_A,
    output logic [31:0]      IBUS_DO,
    input  logic [31:0]      IBUS_DI,
    output logic [3:0]       IBUS_BA,
    output logic             IBUS_WE,
    output logic             IBUS_REQ,
    input  logic             IBUS_BUSY,
    output logic [31:0]      SAR_O,
    output logic [31:0]      DAR_O,
    output logic [TCR_W-1:0] TCR_O,
    output logic             ACTIVE,
    output logic             DONE,
    output logic             AE
);

    DMA_STATE_t       state, state_d;
    DMA_SIZE_t        size_q;
    DMA_AMODE_t       sm_q, dm_q;
    logic [31:0]      sar, dar, data_q;
    logic [TCR_W-1:0] tcr;
    logic             ae_q, abort_q;
    logic             load, set_ae, rd_cap, wr_cmp;
    logic [31:0]      rd_data, wr_data, sar_nx, dar_nx;
    logic [2:0]       unit;

    assign unit   = dma_unit(size_q);
    assign sar_nx = dma_step(sm_q, sar, unit);
    assign dar_nx = dma_step(dm_q, dar, unit);

    // Bus outputs decode purely from registered state, so they are stable for
    // the whole access and hold naturally while the responder stalls.
    always_comb begin
        IBUS_REQ = (state == RD) || (state == WR);
        IBUS_WE  = (state == WR);
        IBUS_A   = 32'd0;
        if (state == RD) IBUS_A = sar;
        if (state == WR) IBUS_A = dar;
    end

    assign IBUS_BA = IBUS_REQ ? DMA_BA(size_q, IBUS_A[1:0]) : 4'b0000;
    assign IBUS_DO = IBUS_WE ? wr_data : 32'd0;

    ibus_lane_align u_lane_align (
        .size   (size_q),
        .a10    (IBUS_A[1:0]),
        .rd_in  (IBUS_DI),
        .wr_in  (data_q),
        .rd_out (rd_data),
        .wr_out (wr_data)
    );

    // Alignment is judged against the address the next state will drive.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        set_ae  = 1'b0;
        rd_cap  = 1'b0;
        wr_cmp  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    load = 1'b1;
                    if (dma_misaligned(DMA_SIZE_t'(SIZE), SRC[1:0])) set_ae = 1'b1;
                    else                                             state_d = RD;
                end
            end
            RD: begin
                if (!IBUS_BUSY) begin
                    rd_cap = 1'b1;
                    if (ABORT) begin
                        state_d = IDLE;
                    end else if (dma_misaligned(size_q, dar[1:0])) begin
                        set_ae  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WR;
                    end
                end
            end
            WR: begin
                if (!IBUS_BUSY) begin
                    wr_cmp = 1'b1;
                    if (tcr == TCR_W'(1) || ABORT) begin
                        state_d = END;
                    end else if (dma_misaligned(size_q, sar_nx[1:0])) begin
                        set_ae  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            END:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            size_q  <= SZ_BYTE;
            sm_q    <= AM_FIXED;
            dm_q    <= AM_FIXED;
            sar     <= 32'd0;
            dar     <= 32'd0;
            data_q  <= 32'd0;
            tcr     <= '0;
            ae_q    <= 1'b0;
            abort_q <= 1'b0;
        end else if (CE_R) begin
            state <= state_d;
            if (load) begin
                sar     <= SRC;
                dar     <= DST;
                tcr     <= COUNT;
                size_q  <= DMA_SIZE_t'(SIZE);
                sm_q    <= DMA_AMODE_t'(SM);
                dm_q    <= DMA_AMODE_t'(DM);
                ae_q    <= 1'b0;
                abort_q <= 1'b0;
            end
            if (set_ae) ae_q <= 1'b1;
            if (rd_cap) data_q <= rd_data;
            if (wr_cmp) begin
                sar     <= sar_nx;
                dar     <= dar_nx;
                tcr     <= tcr - TCR_W'(1);
                abort_q <= ABORT;
            end
        end
    end

    assign SAR_O  = sar;
    assign DAR_O  = dar;
    assign TCR_O  = tcr;
    assign ACTIVE = (state != IDLE);
    assign DONE   = (state == END) && !abort_q;
    assign AE     = ae_q;

endmodule

// File: tb/tb_ibus_dma_channel.sv
// Bench for ibus_dma_channel: directed scenarios plus randomized transfers,
// each checked against a transaction-level model of the copy.
module tb_ibus_dma_channel;

    logic        CLK = 1'b0;
    logic        RST_N, CE_R, START, ABORT, IBUS_BUSY;
    logic [31:0] SRC, DST, IBUS_DI;
    logic [23:0] COUNT;
    logic [1:0]  SIZE, SM, DM;
    logic [31:0] IBUS_A, IBUS_DO, SAR_O, DAR_O;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE, IBUS_REQ, ACTIVE, DONE, AE;
    logic [23:0] TCR_O;

    always #5 CLK = ~CLK;

    ibus_dma_channel #(.TCR_W(24)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .START(START), .ABORT(ABORT),
        .SRC(SRC), .DST(DST), .COUNT(COUNT), .SIZE(SIZE), .SM(SM), .DM(DM),
        .IBUS_A(IBUS_A), .IBUS_DO(IBUS_DO), .IBUS_DI(IBUS_DI), .IBUS_BA(IBUS_BA),
        .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY),
        .SAR_O(SAR_O), .DAR_O(DAR_O), .TCR_O(TCR_O), .ACTIVE(ACTIVE),
        .DONE(DONE), .AE(AE)
    );

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic [3:0]  ba;
        logic [31:0] dat;
    } acc_t;

    acc_t log_q[$];
    int   nvec = 0, nerr = 0;
    int   reqc, actc, donec, brd_left, bwr_left;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model helpers: sizes in bytes, lanes numbered big-endian from bit 31.
    function automatic int nb(input int sz);
        return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    endfunction

    function automatic bit mis(input int sz, input logic [31:0] a);
        return (int'(a[1:0]) % nb(sz)) != 0;
    endfunction

    function automatic logic [3:0] xba(input int sz, input logic [31:0] a);
        logic [3:0] m = 4'b0;
        for (int k = 0; k < nb(sz); k++)
            if (int'(a[1:0]) + k < 4) m[3 - (int'(a[1:0]) + k)] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] extract(input int sz, input logic [31:0] a, input logic [31:0] di);
        logic [63:0] mask = (64'd1 << (8 * nb(sz))) - 64'd1;
        logic [63:0] v = {32'd0, di} >> (8 * (4 - int'(a[1:0]) - nb(sz)));
        return 32'(v & mask);
    endfunction

    function automatic logic [31:0] repl(input int sz, input logic [31:0] v);
        logic [31:0] r = 32'd0;
        for (int k = 0; k < 4 / nb(sz); k++) r = r | (v << (8 * nb(sz) * k));
        return r;
    endfunction

    function automatic logic [31:0] step(input int mode, input logic [31:0] a, input int n);
        if (mode == 1) return a + 32'(n);
        if (mode == 2) return a - 32'(n);
        return a;
    endfunction

    function automatic acc_t lg(input int i);
        if (i < log_q.size()) return log_q[i];
        return '0;
    endfunction

    // One clock: note what completes at the coming edge, then sample #1 after it.
    task automatic cyc();
        logic        hold;
        logic [68:0] snap;
        if (RST_N && CE_R && IBUS_REQ && !IBUS_BUSY)
            log_q.push_back('{IBUS_A, IBUS_WE, IBUS_BA, IBUS_WE ? IBUS_DO : IBUS_DI});
        if (CE_R && IBUS_REQ) reqc++;
        if (CE_R && ACTIVE) actc++;
        if (CE_R && DONE) donec++;
        hold = RST_N && IBUS_REQ && (IBUS_BUSY || !CE_R);
        snap = {IBUS_A, IBUS_WE, IBUS_BA, IBUS_DO};
        @(posedge CLK);
        #1;
        if (hold) chk("hold", {IBUS_A, IBUS_WE, IBUS_BA, IBUS_DO, IBUS_REQ}, {snap, 1'b1});
    endtask

    task automatic check_model(input logic [31:0] src, dst, input int cnt, sz, sm, dm, input bit abrt);
        acc_t        exp_q[$];
        logic [31:0] s = src, d = dst, rdi;
        logic [23:0] tcr_exp;
        int          w = 0, nmin;
        bit          ae = 0;
        for (int i = 0; i < cnt; i++) begin
            if (mis(sz, s)) begin ae = 1; break; end
            rdi = lg(exp_q.size()).dat;
            exp_q.push_back('{s, 1'b0, xba(sz, s), rdi});
            if (mis(sz, d)) begin ae = 1; break; end
            exp_q.push_back('{d, 1'b1, xba(sz, d), repl(sz, extract(sz, s, rdi))});
            s = step(sm, s, nb(sz));
            d = step(dm, d, nb(sz));
            w++;
            if (abrt) break;
        end
        chk("access_count", log_q.size(), exp_q.size());
        nmin = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            if (exp_q[i].we) chk("write_access", log_q[i], exp_q[i]);
            else chk("read_access", {log_q[i].a, log_q[i].we, log_q[i].ba},
                     {exp_q[i].a, exp_q[i].we, exp_q[i].ba});
        end
        tcr_exp = 24'(cnt - w);
        chk("final_sar", SAR_O, s);
        chk("final_dar", DAR_O, d);
        chk("final_tcr", TCR_O, tcr_exp);
        chk("final_ae", AE, ae);
        chk("final_active", ACTIVE, 1'b0);
        chk("done_pulses", donec, (!ae && !abrt) ? 1 : 0);
    endtask

    task automatic run_xfer(input logic [31:0] src, dst, input int cnt, sz, sm, dm,
                            input int busy_pct, ce_pct, brd, bwr, input bit abrt, fixdi);
        int guard = 0;
        SRC = src; DST = dst; COUNT = cnt[23:0]; SIZE = sz[1:0]; SM = sm[1:0]; DM = dm[1:0];
        log_q.delete(); reqc = 0; actc = 0; donec = 0; brd_left = brd; bwr_left = bwr;
        CE_R = 1'b1; IBUS_BUSY = 1'b0; ABORT = 1'b0; START = 1'b1;
        cyc();
        START = 1'b0;
        while (ACTIVE === 1'b1 && guard < 3000) begin
            CE_R = ($urandom_range(99) < ce_pct);
            IBUS_BUSY = ($urandom_range(99) < busy_pct);
            IBUS_DI = fixdi ? 32'h11223344 : $urandom;
            if (IBUS_REQ && !IBUS_WE && brd_left > 0) begin
                IBUS_BUSY = 1'b1; CE_R = 1'b1; brd_left--;
            end
            if (IBUS_REQ && IBUS_WE && bwr_left > 0) begin
                IBUS_BUSY = 1'b1; CE_R = 1'b1; bwr_left--; ABORT = abrt;
            end
            cyc();
            guard++;
        end
        chk("xfer_bound", guard < 3000, 1'b1);
        ABORT = 1'b0; CE_R = 1'b1; IBUS_BUSY = 1'b0;
        check_model(src, dst, cnt, sz, sm, dm, abrt);
    endtask

    initial begin
        int          g, sz;
        logic [31:0] s, d;
        RST_N = 1'b0; CE_R = 1'b1; START = 1'b0; ABORT = 1'b0; IBUS_BUSY = 1'b0;
        SRC = '0; DST = '0; COUNT = '0; SIZE = '0; SM = '0; DM = '0; IBUS_DI = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_bus", {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ}, '0);
        chk("rst_regs", {SAR_O, DAR_O, TCR_O}, '0);
        chk("rst_flags", {ACTIVE, DONE, AE}, '0);
        RST_N = 1'b1;

        // Long copy, increment both, no waits.
        run_xfer(32'h1000, 32'h2000, 3, 2, 1, 1, 0, 100, 0, 0, 0, 0);
        chk("long_req_cycles", reqc, 6);
        chk("long_active_cycles", actc, 7);
        chk("long_addr2", lg(2).a, 32'h1004);
        chk("long_addr5", lg(5).a, 32'h2008);
        chk("long_sar", SAR_O, 32'h100C);
        chk("long_dar", DAR_O, 32'h200C);

        // Byte copy, fixed source, decrementing destination.
        run_xfer(32'h1001, 32'h2003, 2, 0, 0, 2, 0, 100, 0, 0, 0, 1);
        chk("byte_rd_ba", lg(0).ba, 4'b0100);
        chk("byte_wr_ba", lg(1).ba, 4'b0001);
        chk("byte_wr_do", lg(1).dat, 32'h22222222);
        chk("byte_wr2_a", lg(3).a, 32'h2002);

        // Three wait states on the first read.
        run_xfer(32'h3000, 32'h4000, 1, 2, 1, 1, 0, 100, 3, 0, 0, 0);
        chk("wait_req_cycles", reqc, 5);

        // Misaligned word source, then a clean START clears AE.
        run_xfer(32'h1001, 32'h2000, 2, 1, 1, 1, 0, 100, 0, 0, 0, 0);
        chk("mis_ae", AE, 1'b1);
        chk("mis_req_cycles", reqc, 0);
        run_xfer(32'h1002, 32'h2000, 1, 1, 1, 1, 0, 100, 0, 0, 0, 0);
        chk("ae_cleared", AE, 1'b0);

        // ABORT raised while a write is stalled by BUSY.
        run_xfer(32'h5000, 32'h6000, 3, 2, 1, 1, 0, 100, 0, 2, 1, 0);
        chk("abort_accesses", log_q.size(), 2);
        chk("abort_tcr", TCR_O, 24'd2);

        // Reset asserted during a stalled write.
        SRC = 32'h7000; DST = 32'h8000; COUNT = 24'd4; SIZE = 2'd2; SM = 2'd1; DM = 2'd1;
        CE_R = 1'b1; START = 1'b1;
        cyc();
        START = 1'b0;
        g = 0;
        while (!IBUS_WE && g < 20) begin cyc(); g++; end
        chk("rst_wr_reached", IBUS_WE, 1'b1);
        IBUS_BUSY = 1'b1;
        cyc();
        RST_N = 1'b0;
        cyc();
        chk("rst_wr_req", IBUS_REQ, 1'b0);
        chk("rst_wr_bus", {IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ}, '0);
        chk("rst_wr_regs", {SAR_O, DAR_O, TCR_O}, '0);
        chk("rst_wr_flags", {ACTIVE, DONE, AE}, '0);
        RST_N = 1'b1; IBUS_BUSY = 1'b0;
        cyc();

        // Randomized transfers with clock-enable gaps and wait states.
        for (int it = 0; it < 25; it++) begin
            sz = $urandom_range(3);
            s = $urandom;
            d = $urandom;
            if ($urandom_range(9) != 0) s = s & ~32'(nb(sz) - 1);
            if ($urandom_range(9) != 0) d = d & ~32'(nb(sz) - 1);
            run_xfer(s, d, $urandom_range(1, 5), sz, $urandom_range(3), $urandom_range(3),
                     25, 70, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
